// File: rtl/gb_interrupt_ctrl.sv
// gb_interrupt_ctrl: Game Boy IF/IE interrupt controller with CPU vector handshake
// and per-source acknowledge pulses.
module gb_interrupt_ctrl #(
   parameter int          NUM_SRC  = 5,
   parameter logic [15:0] IF_ADDR  = 16'hFF0F,
   parameter logic [15:0] IE_ADDR  = 16'hFFFF,
   parameter logic [15:0] VEC_BASE = 16'h0040
) (
   input  logic               I_CLK33,
   input  logic               I_RESET_L,
   input  logic [NUM_SRC-1:0] I_INT_REQ,
   output logic [NUM_SRC-1:0] O_INT_ACK,
   input  logic               I_MEM_ENABLE,
   input  logic [15:0]        I_ADDR,
   input  logic [7:0]         I_DATA,
   input  logic               I_WE_L,
   input  logic               I_RE_L,
   output logic [7:0]         O_DATA,
   output logic               O_IRQ,
   output logic [15:0]        O_VECTOR,
   input  logic               I_IRQ_ACK
);
   localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   typedef enum logic [1:0] {IDLE, PENDING, SERVICE} state_t;
   state_t             state_q, state_d;
   logic [NUM_SRC-1:0] if_q, if_d, req_prev_q, ack_q, ack_d, rise, pend;
   logic [7:0]         ie_q, ie_d, data_q, data_d;
   logic               irq_q, irq_d, wr, rd;
   logic [15:0]        vector_q, vector_d, sel_vec;
   logic [IW-1:0]      sel, svc_idx;
   assign rise    = I_INT_REQ & ~req_prev_q;
   assign pend    = if_q & ie_q[NUM_SRC-1:0];
   assign wr      = I_MEM_ENABLE & ~I_WE_L;
   assign rd      = I_MEM_ENABLE & ~I_RE_L;
   assign sel_vec = VEC_BASE + 16'({sel, 3'b000});
   assign svc_idx = IW'((vector_q - VEC_BASE) >> 3);
   always_comb begin
      sel = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) if (pend[i]) sel = IW'(i);
   end
   // ack_q is non-zero only during SERVICE, so it doubles as the IF clear mask
   always_comb begin
      if_d   = rise | (~ack_q & ((wr && I_ADDR == IF_ADDR) ? I_DATA[NUM_SRC-1:0] : if_q));
      ie_d   = (wr && I_ADDR == IE_ADDR) ? I_DATA : ie_q;
      data_d = !rd ? 8'h00 :
               (I_ADDR == IF_ADDR) ? {{(8-NUM_SRC){1'b1}}, if_q} :
               (I_ADDR == IE_ADDR) ? ie_q : 8'h00;
   end
   always_comb begin
      state_d  = state_q;
      irq_d    = irq_q;
      vector_d = vector_q;
      ack_d    = '0;
      case (state_q)
         IDLE: if (pend != '0) begin
            state_d  = PENDING;
            irq_d    = 1'b1;
            vector_d = sel_vec;
         end
         PENDING: if (pend == '0) begin
            state_d = IDLE;
            irq_d   = 1'b0;
         end else if (I_IRQ_ACK) begin
            state_d = SERVICE;
            irq_d   = 1'b0;
            ack_d   = NUM_SRC'(1) << svc_idx;
         end else begin
            vector_d = sel_vec;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge I_CLK33 or negedge I_RESET_L) begin
      if (!I_RESET_L) begin
         state_q    <= IDLE;
         if_q       <= '0;
         ie_q       <= '0;
         req_prev_q <= '0;
         ack_q      <= '0;
         irq_q      <= 1'b0;
         vector_q   <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         if_q       <= if_d;
         ie_q       <= ie_d;
         req_prev_q <= I_INT_REQ;
         ack_q      <= ack_d;
         irq_q      <= irq_d;
         vector_q   <= vector_d;
         data_q     <= data_d;
      end
   end
   assign O_INT_ACK = ack_q;
   assign O_IRQ     = irq_q;
   assign O_VECTOR  = vector_q;
   assign O_DATA    = data_q;
endmodule

// File: tb/tb_gb_interrupt_ctrl.sv
// tb_gb_interrupt_ctrl: directed scoreboard bench for gb_interrupt_ctrl.
module tb_gb_interrupt_ctrl;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [4:0]  req = '0, ack;
   logic        en = 1'b0, we_l = 1'b1, re_l = 1'b1, irq_ack = 1'b0, irq;
   logic [15:0] addr = '0, vec;
   logic [7:0]  wdata = '0, rdata;
   logic [15:0] exp_q[$];
   int          vectors = 0, errors = 0;

   gb_interrupt_ctrl dut (
      .I_CLK33(clk), .I_RESET_L(rst_n), .I_INT_REQ(req), .O_INT_ACK(ack),
      .I_MEM_ENABLE(en), .I_ADDR(addr), .I_DATA(wdata), .I_WE_L(we_l), .I_RE_L(re_l),
      .O_DATA(rdata), .O_IRQ(irq), .O_VECTOR(vec), .I_IRQ_ACK(irq_ack)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_v(input logic [15:0] e);
      exp_q.push_back(e);
   endtask

   task automatic check(input string tag, input logic [15:0] obs);
      logic [15:0] e;
      vectors++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
         end
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] e);
      expect_v(e);
      check(tag, obs);
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      en = 1'b1; we_l = 1'b0; addr = a; wdata = d;
      tick();
      en = 1'b0; we_l = 1'b1;
   endtask

   task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] e);
      expect_v(16'(e));
      en = 1'b1; re_l = 1'b0; addr = a;
      tick();
      en = 1'b0; re_l = 1'b1;
      check(tag, 16'(rdata));
   endtask

   initial begin
      #2;
      chk("rst_irq", 16'(irq), 16'h0);
      chk("rst_vec", vec, 16'h0);
      chk("rst_ack", 16'(ack), 16'h0);
      chk("rst_data", 16'(rdata), 16'h0);
      #10 rst_n = 1'b1;
      tick();
      // 1: single VBLANK request
      wr(16'hFFFF, 8'h01);
      req = 5'b00001;
      tick();
      chk("t1_irq_k", 16'(irq), 16'h0);
      req = 5'b00000;
      tick();
      chk("t1_irq_k1", 16'(irq), 16'h1);
      chk("t1_vec", vec, 16'h0040);
      rd("t1_if", 16'hFF0F, 8'hE1);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk("t1_ack", 16'(ack), 16'h0001);
      chk("t1_irq_svc", 16'(irq), 16'h0);
      tick();
      chk("t1_ack_end", 16'(ack), 16'h0);
      rd("t1_if_clr", 16'hFF0F, 8'hE0);
      // 2: preemption by a higher-priority source
      wr(16'hFFFF, 8'h1F);
      req = 5'b00100;
      tick();
      tick();
      chk("t2_irq", 16'(irq), 16'h1);
      chk("t2_vec2", vec, 16'h0050);
      req = 5'b00101;
      tick();
      chk("t2_vec2_hold", vec, 16'h0050);
      tick();
      chk("t2_vec0", vec, 16'h0040);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk("t2_ack0", 16'(ack), 16'h0001);
      chk("t2_irq_m", 16'(irq), 16'h0);
      tick();
      chk("t2_ack_end", 16'(ack), 16'h0);
      chk("t2_irq_m1", 16'(irq), 16'h0);
      tick();
      chk("t2_irq_m2", 16'(irq), 16'h1);
      chk("t2_vec_next", vec, 16'h0050);
      rd("t2_if", 16'hFF0F, 8'hE4);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk("t2_ack2", 16'(ack), 16'h0004);
      tick();
      req = 5'b00000;
      rd("t2_if_clr", 16'hFF0F, 8'hE0);
      // 3: held level sets once; upper IE bits stored but never gate
      wr(16'hFFFF, 8'hA0);
      req = 5'b00010;
      repeat (100) tick();
      chk("t3_irq", 16'(irq), 16'h0);
      rd("t3_if", 16'hFF0F, 8'hE2);
      rd("t3_ie", 16'hFFFF, 8'hA0);
      wr(16'hFF0F, 8'h00);
      rd("t3_if_clr", 16'hFF0F, 8'hE0);
      req = 5'b00000;
      rd("t3_unsel", 16'hFF00, 8'h00);
      // 4: rise beats simultaneous CPU clear
      req = 5'b01000;
      wr(16'hFF0F, 8'h00);
      rd("t4_if", 16'hFF0F, 8'hE8);
      wr(16'hFF0F, 8'h00);
      req = 5'b00000;
      rd("t4_if_clr", 16'hFF0F, 8'hE0);
      // 5: CPU withdraws the enable while pending
      wr(16'hFFFF, 8'h10);
      req = 5'b10000;
      tick();
      req = 5'b00000;
      tick();
      chk("t5_irq", 16'(irq), 16'h1);
      chk("t5_vec", vec, 16'h0060);
      wr(16'hFFFF, 8'h00);
      tick();
      chk("t5_irq_drop", 16'(irq), 16'h0);
      chk("t5_no_ack", 16'(ack), 16'h0);
      rd("t5_if", 16'hFF0F, 8'hF0);
      // 6: reset during SERVICE
      wr(16'hFFFF, 8'h10);
      tick();
      chk("t6_irq", 16'(irq), 16'h1);
      irq_ack = 1'b1;
      tick();
      chk("t6_ack", 16'(ack), 16'h0010);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_ack", 16'(ack), 16'h0);
      chk("t6_rst_irq", 16'(irq), 16'h0);
      chk("t6_rst_vec", vec, 16'h0);
      #1 rst_n = 1'b1;
      irq_ack = 1'b0;
      tick();
      chk("t6_post_ack", 16'(ack), 16'h0);
      chk("t6_post_irq", 16'(irq), 16'h0);
      rd("t6_if", 16'hFF0F, 8'hE0);
      rd("t6_ie", 16'hFFFF, 8'h00);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
